sphere_pair_feeder: RTL and testbench
=====================================

Name: sphere_pair_feeder

Overview:
- Supplies sphere-pair operands (x1,y1,z1,r1,x2,y2,z2,r2; IEEE-754 single) to dCollideSpheres. It is the producer side of the dataFetch request interface.
- A host pushes packed pairs into an internal FIFO. Each rising edge of the collider's dataFetch pops one pair onto registered operand outputs.
- Replaces the bench-side operand driver in synthesised builds. Sits between the host/DMA write path and the collider's input ports.

Parameters:
- DEPTH, 8, FIFO entries (pairs); power of two, 2..64.
- PTR_W, 3, log2(DEPTH); must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all state on posedge.
- rst  input  1  asynchronous, active-low reset.
- wr_valid  input  1  host offers a pair.
- wr_ready  output  1  FIFO can accept; equals (count != DEPTH), combinational from registered count.
- wr_data  input  256  packed pair: [31:0]=x1, [63:32]=y1, [95:64]=z1, [127:96]=r1, [159:128]=x2, [191:160]=y2, [223:192]=z2, [255:224]=r2.
- flush  input  1  synchronous FIFO clear.
- dataFetch  input  1  request from collider; level signal, synchronous to clk.
- x1, y1, z1, r1, x2, y2, z2, r2  output  32 each  registered operands to the collider.
- pair_valid  output  1  operands were loaded by the most recent fetch.
- underrun  output  1  sticky: a fetch arrived while the FIFO was empty.
- level  output  PTR_W+1  current FIFO occupancy.

Behaviour:
- Reset (rst=0, async): FIFO pointers and count cleared, all operand outputs 0, pair_valid=0, underrun=0, fetch_d=0.
  - Reset mid-operation discards every queued pair.
- Push: on posedge with wr_valid && wr_ready, write wr_data at wptr, wptr+1.
  - Pointers wrap mod DEPTH; count is PTR_W+1 bits so full and empty are distinct.
- Fetch detect: fetch_d <= dataFetch every cycle; fetch_rise = dataFetch & ~fetch_d.
  - A level held high issues exactly one request.
  - dataFetch already high at reset release counts as one request, because fetch_d resets to 0.
- Pop on fetch_rise with count>0:
  - Operand regs load from mem[rptr], rptr+1, pair_valid=1.
  - New operands are visible the cycle after the sampling edge (1-cycle latency).
- Fetch_rise with count==0:
  - Operand regs hold their previous values, pair_valid=0, underrun set to 1.
  - underrun stays set until rst or flush.
- No write-to-fetch bypass. A push and a fetch on the same edge while empty is an underrun; the pushed pair stays queued.
- Simultaneous push and pop with 0<count<DEPTH: both occur, count unchanged.
- When full, wr_ready=0 even if a pop happens that edge. No push is accepted that cycle.
- flush:
  - Clears pointers, count and underrun. Operand regs and pair_valid keep their values.
  - flush has priority over push and pop in the same cycle; both are dropped.
- level = count, registered.

Optional Feature:
- Macro SPHERE_FEEDER_STATS_EN.
- When defined: adds output pairs_issued [31:0] and output fetch_misses [15:0].
  - pairs_issued increments on every successful pop and wraps at 2^32.
  - fetch_misses increments on every underrun fetch and saturates at 0xFFFF.
  - Both clear on rst only; flush does not clear them.
- When undefined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Reset then idle: after rst released, all operands 0, pair_valid=0, level=0, wr_ready=1.
- Push pair A (x1=0xBEFC475E, z1=0x3FC00000, r1=0x3F000000, x2=0x3EFC475E, z2=0x3FC00000, r2=0x3F000000), then pulse dataFetch.
  - Expected: one cycle after the rise, outputs equal A exactly, pair_valid=1, level=0.
- Push A then B (x1=0x3F77FB37, z1=0x40800000, z2=0x409EFF6D), then hold dataFetch high 5 cycles followed by a second rise.
  - Expected: A issued once only during the high level, B issued on the second rise.
- Push 8 pairs: wr_ready=0 and level=8. A 9th push with wr_valid=1 is not accepted.
  - A push and a fetch on the same edge while full: pop occurs, level=7, the 9th pair is not written.
- Fetch on an empty FIFO: operands hold previous values, pair_valid=0, underrun=1.
  - A later push plus fetch returns the new pair while underrun stays 1; flush clears underrun.
- Reset mid-stream with 3 pairs queued: level=0 and outputs 0 immediately (asynchronous).
  - With SPHERE_FEEDER_STATS_EN: pairs_issued and fetch_misses also read 0.

Source files
------------

// File: rtl/sphere_pair_feeder.sv
`default_nettype none
// ============================================================================
// Module      : sphere_pair_feeder
// Description : Host-fed FIFO of packed sphere-pair operands (IEEE-754 single)
//               for dCollideSpheres. Each rising edge of the collider's
//               dataFetch level pops one pair onto registered operand outputs.
//
// Ports       : clk                 system clock, all state on posedge
//               rst                 asynchronous active-low reset
//               wr_valid/wr_ready   host push handshake
//               wr_data[255:0]      {r2,z2,y2,x2,r1,z1,y1,x1}, x1 in [31:0]
//               flush               synchronous FIFO clear
//               dataFetch           collider request level
//               x1..r2              registered operands, 32 bits each
//               pair_valid          most recent fetch loaded operands
//               underrun            sticky: fetch while empty
//               level[PTR_W:0]      FIFO occupancy
//
// Options     : SPHERE_FEEDER_STATS_EN adds pairs_issued[31:0] and
//               fetch_misses[15:0] (cleared by rst only).
//
// Revision    : 1.0  initial release
// ============================================================================
module sphere_pair_feeder #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [255:0]     wr_data,
    input  logic             flush,
    input  logic             dataFetch,
    output logic [31:0]      x1,
    output logic [31:0]      y1,
    output logic [31:0]      z1,
    output logic [31:0]      r1,
    output logic [31:0]      x2,
    output logic [31:0]      y2,
    output logic [31:0]      z2,
    output logic [31:0]      r2,
    output logic             pair_valid,
    output logic             underrun,
    output logic [PTR_W:0]   level
`ifdef SPHERE_FEEDER_STATS_EN
    ,
    output logic [31:0]      pairs_issued,
    output logic [15:0]      fetch_misses
`endif
);

    localparam logic [PTR_W:0]   C_FULL    = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   C_CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

    logic [255:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic             r_fetch_d;
    logic [255:0]     r_ops;
    logic             r_pair_valid;
    logic             r_underrun;

    logic w_fetch_rise;
    logic w_push;
    logic w_pop;
    logic w_miss;

    // Full blocks pushes for the whole cycle, even when a pop happens on the
    // same edge, so ready depends on registered count only.
    assign wr_ready     = (r_count != C_FULL);
    assign w_fetch_rise = dataFetch & ~r_fetch_d;
    // flush drops both push and pop in the same cycle.
    assign w_push       = wr_valid & wr_ready & ~flush;
    assign w_pop        = w_fetch_rise & (r_count != '0) & ~flush;
    assign w_miss       = w_fetch_rise & (r_count == '0) & ~flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_fetch_d    <= 1'b0;
            r_ops        <= '0;
            r_pair_valid <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_fetch_d <= dataFetch;
            if (flush) begin
                // Operands and pair_valid intentionally keep their values.
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_count    <= '0;
                r_underrun <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + C_PTR_ONE;
                end
                if (w_pop) begin
                    r_rptr       <= r_rptr + C_PTR_ONE;
                    r_ops        <= r_mem[r_rptr];
                    r_pair_valid <= 1'b1;
                end else if (w_miss) begin
                    // No write-to-fetch bypass: a same-edge push stays queued.
                    r_pair_valid <= 1'b0;
                    r_underrun   <= 1'b1;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + C_CNT_ONE;
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - C_CNT_ONE;
                end
            end
        end
    end

    assign x1         = r_ops[31:0];
    assign y1         = r_ops[63:32];
    assign z1         = r_ops[95:64];
    assign r1         = r_ops[127:96];
    assign x2         = r_ops[159:128];
    assign y2         = r_ops[191:160];
    assign z2         = r_ops[223:192];
    assign r2         = r_ops[255:224];
    assign pair_valid = r_pair_valid;
    assign underrun   = r_underrun;
    assign level      = r_count;

`ifdef SPHERE_FEEDER_STATS_EN
    logic [31:0] r_pairs_issued;
    logic [15:0] r_fetch_misses;

    // Counters survive flush; only rst clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pairs_issued <= '0;
            r_fetch_misses <= '0;
        end else begin
            if (w_pop) begin
                r_pairs_issued <= r_pairs_issued + 32'd1;
            end
            if (w_miss && (r_fetch_misses != 16'hFFFF)) begin
                r_fetch_misses <= r_fetch_misses + 16'd1;
            end
        end
    end

    assign pairs_issued = r_pairs_issued;
    assign fetch_misses = r_fetch_misses;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sphere_pair_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sphere_pair_feeder
// Description : Directed vector bench for sphere_pair_feeder.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sphere_pair_feeder;

    logic         clk;
    logic         rst;
    logic         wr_valid;
    logic         wr_ready;
    logic [255:0] wr_data;
    logic         flush;
    logic         dataFetch;
    logic [31:0]  x1, y1, z1, r1, x2, y2, z2, r2;
    logic         pair_valid;
    logic         underrun;
    logic [3:0]   level;
`ifdef SPHERE_FEEDER_STATS_EN
    logic [31:0]  pairs_issued;
    logic [15:0]  fetch_misses;
`endif

    sphere_pair_feeder #(.DEPTH(8), .PTR_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .flush      (flush),
        .dataFetch  (dataFetch),
        .x1         (x1),
        .y1         (y1),
        .z1         (z1),
        .r1         (r1),
        .x2         (x2),
        .y2         (y2),
        .z2         (z2),
        .r2         (r2),
        .pair_valid (pair_valid),
        .underrun   (underrun),
        .level      (level)
`ifdef SPHERE_FEEDER_STATS_EN
        ,
        .pairs_issued (pairs_issued),
        .fetch_misses (fetch_misses)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [255:0] w_ops = {r2, z2, y2, x2, r1, z1, y1, x1};

    // {r2,z2,y2,x2,r1,z1,y1,x1}
    localparam logic [255:0] C_A = {32'h3F000000, 32'h3FC00000, 32'h00000000, 32'h3EFC475E,
                                     32'h3F000000, 32'h3FC00000, 32'h00000000, 32'hBEFC475E};
    localparam logic [255:0] C_B = {32'h00000000, 32'h409EFF6D, 32'h00000000, 32'h00000000,
                                     32'h00000000, 32'h40800000, 32'h00000000, 32'h3F77FB37};
    localparam logic [255:0] C_Z = '0;

    typedef struct {
        logic         wv;
        logic [255:0] wd;
        logic         fl;
        logic         df;
        logic [255:0] op;
        logic         pv;
        logic         ur;
        logic [3:0]   lvl;
        logic         rdy;
    } vec_t;

    vec_t tbl [22];

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [255:0] op, input logic pv,
                           input logic ur, input logic [3:0] lvl, input logic rdy);
        chk({tag, " ops"},        w_ops, op);
        chk({tag, " pair_valid"}, 256'(pair_valid), 256'(pv));
        chk({tag, " underrun"},   256'(underrun), 256'(ur));
        chk({tag, " level"},      256'(level), 256'(lvl));
        chk({tag, " wr_ready"},   256'(wr_ready), 256'(rdy));
    endtask

    task automatic step(input logic wv, input logic [255:0] wd, input logic fl, input logic df);
        @(negedge clk);
        wr_valid  = wv;
        wr_data   = wd;
        flush     = fl;
        dataFetch = df;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] mk_pair(input int k);
        logic [255:0] p;
        for (int j = 0; j < 8; j++) begin
            p[j*32 +: 32] = 32'h40000000 + 32'(k * 16 + j);
        end
        return p;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //              wv  wd   fl  df   op   pv  ur  lvl   rdy
        tbl[0]  = '{1'b1, C_A, 1'b0, 1'b0, C_Z, 1'b0, 1'b0, 4'd1, 1'b1};
        tbl[1]  = '{1'b0, C_Z, 1'b0, 1'b1, C_A, 1'b1, 1'b0, 4'd0, 1'b1};
        tbl[2]  = '{1'b0, C_Z, 1'b0, 1'b0, C_A, 1'b1, 1'b0, 4'd0, 1'b1};
        tbl[3]  = '{1'b1, C_A, 1'b0, 1'b0, C_A, 1'b1, 1'b0, 4'd1, 1'b1};
        tbl[4]  = '{1'b1, C_B, 1'b0, 1'b0, C_A, 1'b1, 1'b0, 4'd2, 1'b1};
        tbl[5]  = '{1'b0, C_Z, 1'b0, 1'b1, C_A, 1'b1, 1'b0, 4'd1, 1'b1};
        tbl[6]  = '{1'b0, C_Z, 1'b0, 1'b1, C_A, 1'b1, 1'b0, 4'd1, 1'b1};
        tbl[7]  = '{1'b0, C_Z, 1'b0, 1'b1, C_A, 1'b1, 1'b0, 4'd1, 1'b1};
        tbl[8]  = '{1'b0, C_Z, 1'b0, 1'b1, C_A, 1'b1, 1'b0, 4'd1, 1'b1};
        tbl[9]  = '{1'b0, C_Z, 1'b0, 1'b1, C_A, 1'b1, 1'b0, 4'd1, 1'b1};
        tbl[10] = '{1'b0, C_Z, 1'b0, 1'b0, C_A, 1'b1, 1'b0, 4'd1, 1'b1};
        tbl[11] = '{1'b0, C_Z, 1'b0, 1'b1, C_B, 1'b1, 1'b0, 4'd0, 1'b1};
        tbl[12] = '{1'b0, C_Z, 1'b0, 1'b0, C_B, 1'b1, 1'b0, 4'd0, 1'b1};
        tbl[13] = '{1'b0, C_Z, 1'b0, 1'b1, C_B, 1'b0, 1'b1, 4'd0, 1'b1};
        tbl[14] = '{1'b0, C_Z, 1'b0, 1'b0, C_B, 1'b0, 1'b1, 4'd0, 1'b1};
        tbl[15] = '{1'b1, C_A, 1'b0, 1'b1, C_B, 1'b0, 1'b1, 4'd1, 1'b1};
        tbl[16] = '{1'b0, C_Z, 1'b0, 1'b0, C_B, 1'b0, 1'b1, 4'd1, 1'b1};
        tbl[17] = '{1'b0, C_Z, 1'b0, 1'b1, C_A, 1'b1, 1'b1, 4'd0, 1'b1};
        tbl[18] = '{1'b0, C_Z, 1'b1, 1'b0, C_A, 1'b1, 1'b0, 4'd0, 1'b1};
        tbl[19] = '{1'b1, C_B, 1'b0, 1'b0, C_A, 1'b1, 1'b0, 4'd1, 1'b1};
        tbl[20] = '{1'b1, C_A, 1'b1, 1'b1, C_A, 1'b1, 1'b0, 4'd0, 1'b1};
        tbl[21] = '{1'b0, C_Z, 1'b0, 1'b0, C_A, 1'b1, 1'b0, 4'd0, 1'b1};

        rst       = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        flush     = 1'b0;
        dataFetch = 1'b0;
        #3;
        chk_all("reset", C_Z, 1'b0, 1'b0, 4'd0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_all("idle", C_Z, 1'b0, 1'b0, 4'd0, 1'b1);

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].wv, tbl[i].wd, tbl[i].fl, tbl[i].df);
            chk_all($sformatf("vec%0d", i), tbl[i].op, tbl[i].pv, tbl[i].ur, tbl[i].lvl, tbl[i].rdy);
        end
`ifdef SPHERE_FEEDER_STATS_EN
        chk("stats pairs_issued", 256'(pairs_issued), 256'(32'd4));
        chk("stats fetch_misses", 256'(fetch_misses), 256'(16'd2));
`endif

        // Fill to full, pointers start at 0 after the flush and wrap on the 8th push.
        for (int k = 0; k < 8; k++) begin
            step(1'b1, mk_pair(k), 1'b0, 1'b0);
            chk($sformatf("fill%0d level", k), 256'(level), 256'(k + 1));
            chk($sformatf("fill%0d wr_ready", k), 256'(wr_ready), 256'(k < 7));
        end
        step(1'b1, mk_pair(8), 1'b0, 1'b0);
        chk_all("full push", C_A, 1'b1, 1'b0, 4'd8, 1'b0);
        // Push blocked while full even though a pop happens this edge.
        step(1'b1, mk_pair(8), 1'b0, 1'b1);
        chk_all("full push+pop", mk_pair(0), 1'b1, 1'b0, 4'd7, 1'b1);
        for (int k = 1; k < 8; k++) begin
            step(1'b0, C_Z, 1'b0, 1'b0);
            step(1'b0, C_Z, 1'b0, 1'b1);
            chk_all($sformatf("drain%0d", k), mk_pair(k), 1'b1, 1'b0, 4'(7 - k), 1'b1);
        end
        step(1'b0, C_Z, 1'b0, 1'b0);
        step(1'b0, C_Z, 1'b0, 1'b1);
        chk_all("drained underrun", mk_pair(7), 1'b0, 1'b1, 4'd0, 1'b1);
`ifdef SPHERE_FEEDER_STATS_EN
        chk("stats2 pairs_issued", 256'(pairs_issued), 256'(32'd12));
        chk("stats2 fetch_misses", 256'(fetch_misses), 256'(16'd3));
`endif

        // Asynchronous reset with three pairs queued.
        step(1'b1, C_A, 1'b0, 1'b0);
        step(1'b1, C_B, 1'b0, 1'b0);
        step(1'b1, C_A, 1'b0, 1'b0);
        chk("queued level", 256'(level), 256'(4'd3));
        @(negedge clk);
        wr_valid  = 1'b0;
        dataFetch = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk_all("async reset", C_Z, 1'b0, 1'b0, 4'd0, 1'b1);
`ifdef SPHERE_FEEDER_STATS_EN
        chk("rst pairs_issued", 256'(pairs_issued), 256'(32'd0));
        chk("rst fetch_misses", 256'(fetch_misses), 256'(16'd0));
`endif
        // dataFetch already high at release is one request; FIFO is empty.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_all("fetch at release", C_Z, 1'b0, 1'b1, 4'd0, 1'b1);
`ifdef SPHERE_FEEDER_STATS_EN
        chk("release fetch_misses", 256'(fetch_misses), 256'(16'd1));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
